// File: rtl/psram_pkg.sv
// ---------------------------------------------------------------------------
// psram_pkg
//   Shared types and constants for the PSRAM access arbiter.
//   - psram_arb_state_t : arbiter FSM state encoding
//   - psram_req_t       : one latched access (type, address, write data)
//   - PSRAM_AW/PSRAM_DW : controller address / data widths
//   - TMO_RDAT          : read data returned for an access that timed out
// ---------------------------------------------------------------------------
package psram_pkg;

  localparam int PSRAM_AW = 24;
  localparam int PSRAM_DW = 16;

  localparam logic [PSRAM_DW-1:0] TMO_RDAT = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,  // waiting for a request
    ISSUE = 3'd1,  // strobe cycle towards the controller
    LAT   = 3'd2,  // controller busy-reporting latency
    WAIT  = 3'd3,  // waiting for busy to fall (or timeout)
    RESP  = 3'd4   // response pulse to the owner
  } psram_arb_state_t;

  typedef struct packed {
    logic                we;
    logic [PSRAM_AW-1:0] addr;
    logic [PSRAM_DW-1:0] wdat;
  } psram_req_t;

endpackage

// File: rtl/psram_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin selector. Searches upward from
//   last_grant_i + 1 (modulo NREQ) and returns the first valid index.
//
//   valid_i      in  NREQ  request vector
//   last_grant_i in  IW    index granted last time
//   grant_o      out IW    selected index (meaningful when any_valid_o)
//   any_valid_o  out 1     at least one request is valid
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter  int NREQ = 2,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IW-1:0]   last_grant_i,
  output logic [IW-1:0]   grant_o,
  output logic            any_valid_o
);

  // One extra bit so last_grant + offset never overflows before the wrap.
  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0] cand;

  // NOTE: every signal written in an always_comb gets a default first;
  // a path that leaves one unassigned would infer a latch.
  always_comb begin
    grant_o     = last_grant_i;
    any_valid_o = 1'b0;
    cand        = '0;
    // Offsets 1..NREQ visit every index exactly once, the previous winner last.
    for (int i = 1; i <= NREQ; i++) begin
      cand = {1'b0, last_grant_i} + (IW+1)'(i);
      if (cand >= NREQ_W) begin
        cand = cand - NREQ_W;
      end
      if (!any_valid_o && valid_i[cand[IW-1:0]]) begin
        grant_o     = cand[IW-1:0];
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/psram_arb.sv
// ---------------------------------------------------------------------------
// psram_arb
//   Round-robin arbiter giving NREQ requesters serialized access to a single
//   PSRAM controller. One access is outstanding at a time; the controller
//   reports progress with psram_busy, which is first examined BUSY_LAT cycles
//   after the strobe. A busy that never falls is cut off after TMO_CYC cycles
//   with a dummy response and a sticky error flag.
//
//   clk        in  1          rising-edge clock
//   arst_n     in  1          asynchronous active-low reset
//   req_valid  in  NREQ       per-requester request
//   req_we     in  NREQ       per-requester access type (1 = write)
//   req_addr   in  NREQ x 24  per-requester address
//   req_wdat   in  NREQ x 16  per-requester write data
//   req_ready  out NREQ       one-hot grant pulse (request accepted)
//   rsp_valid  out NREQ       one-hot completion pulse
//   rsp_rdat   out 16         read data, held between responses
//   psram_stb  out 1          one-cycle access strobe
//   psram_we   out 1          write qualifier, valid with psram_stb
//   psram_addr out 24         access address, stable grant..completion
//   psram_din  out 16         write data, stable grant..completion
//   psram_busy in  1          controller executing an access
//   psram_rdat in  16         controller read data, valid as busy falls
//   err_tmo    out 1          sticky: an access timed out
// ---------------------------------------------------------------------------
module psram_arb
  import psram_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int BUSY_LAT = 2,
  parameter int TMO_CYC  = 1024
) (
  input  logic                           clk,
  input  logic                           arst_n,
  input  logic [NREQ-1:0]                req_valid,
  input  logic [NREQ-1:0]                req_we,
  input  logic [NREQ-1:0][PSRAM_AW-1:0]  req_addr,
  input  logic [NREQ-1:0][PSRAM_DW-1:0]  req_wdat,
  output logic [NREQ-1:0]                req_ready,
  output logic [NREQ-1:0]                rsp_valid,
  output logic [PSRAM_DW-1:0]            rsp_rdat,
  output logic                           psram_stb,
  output logic                           psram_we,
  output logic [PSRAM_AW-1:0]            psram_addr,
  output logic [PSRAM_DW-1:0]            psram_din,
  input  logic                           psram_busy,
  input  logic [PSRAM_DW-1:0]            psram_rdat,
  output logic                           err_tmo
);

  localparam int IW = $clog2(NREQ);
  localparam int LW = $clog2(BUSY_LAT + 1);
  localparam int TW = $clog2(TMO_CYC + 1);

  localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(BUSY_LAT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TMO_CYC - 1);
  localparam logic [TW-1:0] TMO_MAX   = TW'(TMO_CYC);

  psram_arb_state_t    state_q, state_d;
  psram_req_t          cur_q, cur_d;
  logic [IW-1:0]       last_grant_q, last_grant_d;
  logic [IW-1:0]       owner_q, owner_d;
  logic [LW-1:0]       lat_q, lat_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                stb_q, stb_d;
  logic                we_q, we_d;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_d;
  logic [PSRAM_DW-1:0] rsp_rdat_q, rsp_rdat_d;
  logic                err_tmo_q, err_tmo_d;

  // Cleared asynchronously by reset and set on the first clock afterwards:
  // keeps the combinational req_ready low for as long as reset is applied,
  // even though IDLE is the reset state.
  logic                ready_en_q;

  logic [IW-1:0]       pick;
  logic                any_valid;

  rr_pick #(
    .NREQ (NREQ)
  ) u_rr_pick (
    .valid_i      (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (pick),
    .any_valid_o  (any_valid)
  );

  // -------------------------------------------------------------------------
  // Next-state and combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    lat_d        = lat_q;
    tmo_d        = tmo_q;
    stb_d        = 1'b0;
    we_d         = 1'b0;
    rsp_valid_d  = '0;
    rsp_rdat_d   = rsp_rdat_q;
    err_tmo_d    = err_tmo_q;
    req_ready    = '0;

    unique case (state_q)
      IDLE: begin
        // Grant is decided here; the strobe and latched payload appear on
        // the very next cycle.
        if (ready_en_q && any_valid) begin
          req_ready[pick] = 1'b1;
          owner_d         = pick;
          last_grant_d    = pick;
          cur_d.we        = req_we[pick];
          cur_d.addr      = req_addr[pick];
          cur_d.wdat      = req_wdat[pick];
          stb_d           = 1'b1;
          we_d            = req_we[pick];
          state_d         = ISSUE;
        end
      end

      ISSUE: begin
        lat_d   = '0;
        tmo_d   = '0;
        state_d = LAT;
      end

      LAT: begin
        if (lat_q == LAT_LAST) begin
          state_d = WAIT;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      WAIT: begin
        if (!psram_busy) begin
          rsp_valid_d[owner_q] = 1'b1;
          if (!cur_q.we) begin
            rsp_rdat_d = psram_rdat;
          end
          state_d = RESP;
        end else begin
          if (tmo_q != TMO_MAX) begin
            tmo_d = tmo_q + 1'b1;
          end
          // The counter reaches TMO_CYC on this edge: abandon the access.
          if (tmo_q == TMO_LAST) begin
            err_tmo_d            = 1'b1;
            rsp_valid_d[owner_q] = 1'b1;
            rsp_rdat_d           = TMO_RDAT;
            state_d              = IDLE;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      last_grant_q <= LAST_INIT;
      owner_q      <= '0;
      lat_q        <= '0;
      tmo_q        <= '0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_rdat_q   <= '0;
      err_tmo_q    <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      lat_q        <= lat_d;
      tmo_q        <= tmo_d;
      stb_q        <= stb_d;
      we_q         <= we_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdat_q   <= rsp_rdat_d;
      err_tmo_q    <= err_tmo_d;
      ready_en_q   <= 1'b1;
    end
  end

  assign psram_stb  = stb_q;
  assign psram_we   = we_q;
  assign psram_addr = cur_q.addr;
  assign psram_din  = cur_q.wdat;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdat   = rsp_rdat_q;
  assign err_tmo    = err_tmo_q;

endmodule

// File: tb/tb_psram_arb.sv
// ---------------------------------------------------------------------------
// tb_psram_arb
//   Directed bench for psram_arb (NREQ=2, BUSY_LAT=2, TMO_CYC=64) with a
//   small PSRAM controller model that raises busy on each strobe and drops
//   it a programmable number of cycles later (or never).
// ---------------------------------------------------------------------------
module tb_psram_arb;
  import psram_pkg::*;

  localparam int NREQ     = 2;
  localparam int BUSY_LAT = 2;
  localparam int TMO_CYC  = 64;

  logic                          clk;
  logic                          arst_n;
  logic [NREQ-1:0]               req_valid;
  logic [NREQ-1:0]               req_we;
  logic [NREQ-1:0][PSRAM_AW-1:0] req_addr;
  logic [NREQ-1:0][PSRAM_DW-1:0] req_wdat;
  logic [NREQ-1:0]               req_ready;
  logic [NREQ-1:0]               rsp_valid;
  logic [PSRAM_DW-1:0]           rsp_rdat;
  logic                          psram_stb;
  logic                          psram_we;
  logic [PSRAM_AW-1:0]           psram_addr;
  logic [PSRAM_DW-1:0]           psram_din;
  logic                          psram_busy;
  logic [PSRAM_DW-1:0]           psram_rdat;
  logic                          err_tmo;

  psram_arb #(
    .NREQ     (NREQ),
    .BUSY_LAT (BUSY_LAT),
    .TMO_CYC  (TMO_CYC)
  ) dut (
    .clk        (clk),
    .arst_n     (arst_n),
    .req_valid  (req_valid),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdat   (req_wdat),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdat   (rsp_rdat),
    .psram_stb  (psram_stb),
    .psram_we   (psram_we),
    .psram_addr (psram_addr),
    .psram_din  (psram_din),
    .psram_busy (psram_busy),
    .psram_rdat (psram_rdat),
    .err_tmo    (err_tmo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  initial forever @(posedge clk) cyc++;

  typedef struct {
    int                  cyc;
    logic                we;
    logic [PSRAM_AW-1:0] addr;
    logic [PSRAM_DW-1:0] din;
  } stb_rec_t;

  typedef struct {
    int                  cyc;
    logic [NREQ-1:0]     vec;
    logic [PSRAM_DW-1:0] rdat;
    logic [PSRAM_AW-1:0] addr;
  } rsp_rec_t;

  stb_rec_t        stb_q[$];
  rsp_rec_t        rsp_q[$];
  logic [NREQ-1:0] grant_q[$];
  int              grant_cyc_q[$];

  // ---------------- PSRAM controller model ----------------
  logic [PSRAM_DW-1:0] mem [logic [PSRAM_AW-1:0]];
  int                  busy_hold  = 20;
  bit                  never_drop = 1'b0;
  int                  left       = 0;
  int                  fall_cyc   = 0;
  int                  overlap_cnt = 0;
  logic [PSRAM_AW-1:0] pend_addr  = '0;
  logic                pend_we    = 1'b0;

  initial begin
    psram_busy = 1'b0;
    psram_rdat = 16'h0000;
    forever begin
      @(negedge clk);
      if (psram_stb && psram_busy) overlap_cnt++;
      if (!arst_n) begin
        psram_busy = 1'b0;
        left       = 0;
      end else if (psram_busy) begin
        if (!never_drop) begin
          left--;
          if (left <= 0) begin
            psram_busy = 1'b0;
            fall_cyc   = cyc;
            if (!pend_we) psram_rdat = mem.exists(pend_addr) ? mem[pend_addr] : 16'h0000;
          end
        end
      end else if (psram_stb) begin
        stb_q.push_back('{cyc: cyc, we: psram_we, addr: psram_addr, din: psram_din});
        pend_addr = psram_addr;
        pend_we   = psram_we;
        if (psram_we) mem[psram_addr] = psram_din;
        psram_busy = 1'b1;
        left       = busy_hold;
      end
    end
  end

  // ---------------- response monitor ----------------
  initial forever begin
    @(negedge clk);
    if (rsp_valid != '0)
      rsp_q.push_back('{cyc: cyc, vec: rsp_valid, rdat: rsp_rdat, addr: psram_addr});
  end

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requesters: sample grant at the falling edge, retire the request just
  // after the rising edge that accepted it (unless held continuously).
  logic [NREQ-1:0] keep = '0;

  task automatic tick();
    logic [NREQ-1:0] r;
    @(negedge clk);
    r = req_ready;
    if (r != '0) begin
      grant_q.push_back(r);
      grant_cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++)
      if (r[i] && !keep[i]) req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(input int n_total, input int budget, input string tag);
    int k = 0;
    while (rsp_q.size() < n_total && k < budget) begin
      tick();
      k++;
    end
    check(tag, rsp_q.size(), n_total);
  endtask

  task automatic wait_grant(input int n_total, input int budget, input string tag);
    int k = 0;
    while (grant_q.size() < n_total && k < budget) begin
      tick();
      k++;
    end
    check(tag, grant_q.size(), n_total);
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"},  req_ready,  0);
    check({pfx, "_rsp_valid"},  rsp_valid,  0);
    check({pfx, "_stb"},        psram_stb,  0);
    check({pfx, "_we"},         psram_we,   0);
    check({pfx, "_addr"},       psram_addr, 0);
    check({pfx, "_din"},        psram_din,  0);
    check({pfx, "_rdat"},       rsp_rdat,   0);
    check({pfx, "_err_tmo"},    err_tmo,    0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  int s_b, r_b, g_b;

  initial begin
    arst_n    = 1'b1;
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdat  = '0;

    // ---------------- reset ----------------
    #2 arst_n = 1'b0;
    #1 check_reset_outputs("rst");
    req_valid = '1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready_gated", req_ready, 0);
    check("rst_stb_held",    psram_stb, 0);
    req_valid = '0;
    arst_n    = 1'b1;
    tick();
    tick();

    // ---------------- S1: requester 0 write ----------------
    s_b = stb_q.size(); r_b = rsp_q.size(); g_b = grant_q.size();
    busy_hold   = 20;
    req_we[0]   = 1'b1;
    req_addr[0] = 24'h000123;
    req_wdat[0] = 16'hBEEF;
    req_valid[0] = 1'b1;
    wait_rsp(r_b + 1, 200, "s1_rsp_count");
    check("s1_grant",       grant_q[g_b], 2'b01);
    check("s1_stb_count",   stb_q.size() - s_b, 1);
    check("s1_stb_we",      stb_q[s_b].we, 1);
    check("s1_stb_addr",    stb_q[s_b].addr, 24'h000123);
    check("s1_stb_din",     stb_q[s_b].din, 16'hBEEF);
    check("s1_grant2stb",   stb_q[s_b].cyc - grant_cyc_q[g_b], 1);
    check("s1_rsp_vec",     rsp_q[r_b].vec, 2'b01);
    check("s1_busy2rsp",    rsp_q[r_b].cyc - fall_cyc, 1);
    check("s1_addr_held",   rsp_q[r_b].addr, 24'h000123);

    // ---------------- S2: requester 1 read ----------------
    s_b = stb_q.size(); r_b = rsp_q.size(); g_b = grant_q.size();
    req_we[1]   = 1'b0;
    req_addr[1] = 24'h000123;
    req_valid[1] = 1'b1;
    wait_rsp(r_b + 1, 200, "s2_rsp_count");
    check("s2_grant",     grant_q[g_b], 2'b10);
    check("s2_stb_we",    stb_q[s_b].we, 0);
    check("s2_stb_addr",  stb_q[s_b].addr, 24'h000123);
    check("s2_rsp_vec",   rsp_q[r_b].vec, 2'b10);
    check("s2_rsp_rdat",  rsp_q[r_b].rdat, 16'hBEEF);
    check("s2_busy2rsp",  rsp_q[r_b].cyc - fall_cyc, 1);
    repeat (3) tick();
    check("s2_rdat_hold", rsp_rdat, 16'hBEEF);

    // ---------------- S3: both continuously valid ----------------
    s_b = stb_q.size(); r_b = rsp_q.size(); g_b = grant_q.size();
    keep        = '1;
    req_we      = 2'b11;
    req_addr[0] = 24'h000010;
    req_wdat[0] = 16'h1111;
    req_addr[1] = 24'h000020;
    req_wdat[1] = 16'h2222;
    req_valid   = 2'b11;
    wait_grant(g_b + 6, 400, "s3_grant_count");
    keep      = '0;
    req_valid = '0;
    wait_rsp(r_b + 6, 300, "s3_rsp_count");
    repeat (5) tick();
    for (int k = 0; k < 6; k++) begin
      check($sformatf("s3_grant%0d", k), grant_q[g_b + k], (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("s3_rsp%0d", k),   rsp_q[r_b + k].vec, (k % 2 == 0) ? 2'b01 : 2'b10);
    end
    check("s3_stb_count",   stb_q.size() - s_b, 6);
    check("s3_no_extra",    grant_q.size() - g_b, 6);
    check("s3_stb_overlap", overlap_cnt, 0);

    // ---------------- S4: timeout ----------------
    s_b = stb_q.size(); r_b = rsp_q.size(); g_b = grant_q.size();
    never_drop  = 1'b1;
    req_we[0]   = 1'b0;
    req_addr[0] = 24'h000456;
    req_valid[0] = 1'b1;
    wait_rsp(r_b + 1, 300, "s4_rsp_count");
    check("s4_rsp_vec",   rsp_q[r_b].vec, 2'b01);
    check("s4_rsp_rdat",  rsp_q[r_b].rdat, 16'hDEAD);
    check("s4_err_tmo",   err_tmo, 1);
    check("s4_latency",   rsp_q[r_b].cyc - stb_q[s_b].cyc, 1 + BUSY_LAT + TMO_CYC);
    never_drop = 1'b0;
    for (int k = 0; k < 100 && psram_busy; k++) tick();
    check("s4_busy_release", psram_busy, 0);
    s_b = stb_q.size(); r_b = rsp_q.size();
    req_we[1]   = 1'b1;
    req_addr[1] = 24'h000777;
    req_wdat[1] = 16'h1234;
    req_valid[1] = 1'b1;
    wait_rsp(r_b + 1, 200, "s4_next_rsp_count");
    check("s4_next_vec",     rsp_q[r_b].vec, 2'b10);
    check("s4_next_addr",    stb_q[s_b].addr, 24'h000777);
    check("s4_next_din",     stb_q[s_b].din, 16'h1234);
    check("s4_err_sticky",   err_tmo, 1);
    check("s4_rdat_on_wr",   rsp_rdat, 16'hDEAD);

    // ---------------- S5: reset during WAIT ----------------
    s_b = stb_q.size();
    busy_hold   = 20;
    req_we[0]   = 1'b1;
    req_addr[0] = 24'h000555;
    req_wdat[0] = 16'hAAAA;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 50 && stb_q.size() == s_b; k++) tick();
    check("s5_stb_seen", stb_q.size() - s_b, 1);
    repeat (6) tick();
    check("s5_in_access", psram_addr, 24'h000555);
    r_b = rsp_q.size();
    @(negedge clk);
    #1 arst_n = 1'b0;
    #1 check_reset_outputs("s5");
    repeat (3) tick();
    arst_n = 1'b1;
    repeat (30) tick();
    check("s5_no_rsp", rsp_q.size() - r_b, 0);
    g_b = grant_q.size(); r_b = rsp_q.size();
    req_we    = 2'b00;
    req_valid = 2'b11;
    wait_grant(g_b + 1, 20, "s5_grant_count");
    check("s5_first_grant", grant_q[g_b], 2'b01);
    wait_rsp(r_b + 2, 200, "s5_rsp_count");
    check("s5_second_grant", grant_q[g_b + 1], 2'b10);

    // ---------------- S6: withdrawal during service ----------------
    s_b = stb_q.size(); r_b = rsp_q.size(); g_b = grant_q.size();
    req_we[1]    = 1'b0;
    req_addr[1]  = 24'h000123;
    req_valid[1] = 1'b1;
    wait_grant(g_b + 1, 20, "s6_grant_count");
    check("s6_grant", grant_q[g_b], 2'b10);
    repeat (3) tick();
    req_we[0]    = 1'b1;
    req_addr[0]  = 24'h000999;
    req_valid[0] = 1'b1;
    repeat (4) tick();
    req_valid[0] = 1'b0;
    wait_rsp(r_b + 1, 200, "s6_rsp_count");
    check("s6_rsp_vec",  rsp_q[r_b].vec, 2'b10);
    check("s6_rsp_rdat", rsp_q[r_b].rdat, 16'hBEEF);
    repeat (30) tick();
    check("s6_no_grant0",  grant_q.size() - g_b, 1);
    check("s6_stb_count",  stb_q.size() - s_b, 1);
    check("end_stb_overlap", overlap_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
